// File: rtl/prod_accumulator_if.sv
// Product-in / sum-out stream bundle for the multiply-accumulate datapath.
// The master drives products and takes sums; the slave is the accumulator.
interface prod_accumulator_if #(
    parameter int unsigned PROD_W = 8,
    parameter int unsigned ACC_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] product;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  sum;
    logic              overflow;

    modport master (
        output in_valid, product, out_ready,
        input  in_ready, out_valid, sum, overflow
    );

    modport slave (
        input  in_valid, product, out_ready,
        output in_ready, out_valid, sum, overflow
    );
endinterface

// File: rtl/prod_accumulator.sv
// Sums blocks of COUNT unsigned products and presents each block sum with a
// sticky carry-out flag over a valid/ready handshake.
module prod_accumulator #(
    parameter int unsigned PROD_W = 8,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned COUNT  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    prod_accumulator_if.slave   bus
);
    typedef enum logic {StAccum, StHold} state_e;

    localparam logic [7:0] LastCnt = 8'(COUNT - 1);

    state_e           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [7:0]       r_cnt;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [ACC_W:0]   w_add;

    // Extra top bit captures the carry out of the accumulator width.
    always_comb begin
        w_add = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, bus.product};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StAccum;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_state     <= StAccum;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                StAccum: begin
                    if (bus.in_valid) begin
                        r_acc <= w_add[ACC_W-1:0];
                        r_ovf <= r_ovf | w_add[ACC_W];
                        if (r_cnt == LastCnt) begin
                            r_cnt       <= '0;
                            r_state     <= StHold;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                StHold: begin
                    if (bus.out_ready) begin
                        r_acc       <= '0;
                        r_ovf       <= 1'b0;
                        r_state     <= StAccum;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_acc;
    assign bus.overflow  = r_ovf;
endmodule

// File: doc/prod_accumulator.md
# prod_accumulator

Sequential accumulator directly downstream of `multiplier_4bit`. It consumes a stream of 8-bit products over a valid/ready handshake and sums each group of `COUNT` products into one wide result. Each completed sum is presented on an output valid/ready port. It forms the accumulate half of a multiply-accumulate datapath.

## Interface

**Parameters**
- `PROD_W`, default 8: width of the incoming product.
- `ACC_W`, default 16: width of the accumulator and `sum`; must be ≥ `PROD_W`.
- `COUNT`, default 4: products per block; range 1..255.

**Ports**
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `clear`  input  1: synchronous flush; discards any partial block.
- `in_valid`  input  1: `product` is valid.
- `in_ready`  output  1: block can accept a product this cycle.
- `product`  input  `PROD_W`: unsigned product from the multiplier.
- `out_valid`  output  1: `sum` and `overflow` are valid.
- `out_ready`  input  1: consumer accepts the result this cycle.
- `sum`  output  `ACC_W`: unsigned sum of `COUNT` products, modulo 2^`ACC_W`.
- `overflow`  output  1: at least one carry out of `ACC_W` occurred during this block.

## Operation

**States:** ACCUM, HOLD. Registers are the accumulator `acc`, counter `cnt` (8 bit), and the sticky flag `ovf`.

**Reset values:** state = ACCUM, `acc` = 0, `cnt` = 0, `ovf` = 0. Outputs after reset: `in_ready` = 1, `out_valid` = 0, `sum` = 0, `overflow` = 0.

**ACCUM**
- `in_ready` = 1 and `out_valid` = 0.
- An accept is `in_valid && in_ready` at a rising edge.
- On accept: `acc` ← `acc + product` (zero-extended, modulo 2^`ACC_W`); `ovf` ← `ovf` OR carry-out; `cnt` ← `cnt + 1`.
- The accept that makes `cnt` reach `COUNT` moves the block to HOLD. `cnt` resets to 0 on that transition.

**HOLD**
- `in_ready` = 0 and `out_valid` = 1.
- `sum` = `acc` and `overflow` = `ovf`; both hold stable while `out_ready` is low.
- On `out_valid && out_ready`: `acc` ← 0, `ovf` ← 0, state ← ACCUM.

**Priority:** `rst` > `clear` > handshakes.
- `clear` = 1 at an edge sets `acc` = 0, `cnt` = 0, `ovf` = 0 and state = ACCUM, from either state.
- In HOLD this drops the pending result without an out handshake.
- A product offered in the same cycle as `clear` is not accepted.

**Outputs:** `sum` and `overflow` are driven directly from `acc` and `ovf`. They are meaningful only while `out_valid` = 1.

**Idle input:** with `in_valid` = 0 in ACCUM, nothing changes.

## Timing

- **Input throughput:** one product per cycle while in ACCUM.
- **Result latency:** `out_valid` rises in the cycle after the edge that accepts the `COUNT`th product.
- **Minimum block period:** `COUNT` + 1 cycles. That is `COUNT` accept cycles plus one HOLD cycle when `out_ready` is held at 1.
- **No input/output overlap:** while a result is pending, `in_ready` = 0. The upstream multiplier stage must hold `product` and `in_valid`.
- **Return to ACCUM:** `in_ready` returns to 1 in the cycle after the output handshake.
- **`COUNT` = 1:** alternates ACCUM/HOLD; each product appears as `sum` one cycle after acceptance.
- **Reset mid-operation:** asynchronous `rst` immediately forces the reset values, regardless of state or `cnt`. The partial or pending sum is lost.
- **Wrap-around:**
  - `acc` wraps modulo 2^`ACC_W`.
  - `ovf` records any carry within the block and is never cleared by wrap.
  - With the defaults, 4 × 225 = 900 cannot overflow.

## Test plan

1. **Basic block:** defaults; offer products 225, 225, 225, 225 back-to-back with `out_ready` = 1. Required: `in_ready` = 1 for all four accepts; `out_valid` = 1 one cycle later with `sum` = 900 and `overflow` = 0; `in_ready` = 1 again the following cycle.
2. **Backpressure:** products 3, 6, 9, 12 with `out_ready` = 0 for 5 cycles after completion. Required: `sum` = 30 held stable with `in_ready` = 0 throughout; after `out_ready` = 1 for one cycle, `out_valid` = 0 and `acc` = 0.
3. **Input bubbles:** products 1, (gap 2 cycles), 2, (gap), 4, 8 with `in_valid` toggling. Required: `sum` = 15; gaps do not advance `cnt`.
4. **Clear mid-block:** accept 50, 60, then assert `clear` together with `in_valid` and product = 70, then feed 1, 1, 1, 1. Required: 70 is not accepted; next `sum` = 4.
5. **Overflow:** `ACC_W` = 9, `COUNT` = 4; products 200, 200, 200, 200. Required: `sum` = 800 mod 512 = 288 and `overflow` = 1; the next block of 1, 1, 1, 1 gives `sum` = 4 and `overflow` = 0.
6. **Async reset:** assert `rst` between clock edges while in HOLD. Required: `out_valid` = 0, `in_ready` = 1 and `sum` = 0 immediately, before the next clock edge; after release, products 10, 20, 30, 40 give `sum` = 100.
